wb_stream_master: RTL and testbench

Byte-stream-driven Wishbone master that lets an external command source, such as a host UART or debug link, read and write any slave on the SoC interconnect. It sits in a master slot of the interconnect, beside the CPU. Each command is parsed from an 8-bit valid/ready input stream and executed as a single Wishbone classic cycle. A status byte, plus read data for reads, is returned on an 8-bit valid/ready output stream.

---
 rtl/wb_stream_master_if.sv | 35 +++
 rtl/wb_stream_master.sv | 176 +++++++++++++++++
 tb/tb_wb_stream_master.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_stream_master_if.sv
// Bundle of the command/response byte streams and the Wishbone master port.
// The master modport is the view of wb_stream_master; the slave modport is the
// view of whatever sits on the other side (host link, interconnect, bench).
interface wb_stream_master_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  wb_cyc;
  logic                  wb_stb;
  logic                  wb_we;
  logic                  wb_tag;
  logic [3:0]            wb_sel;
  logic [ADDR_WIDTH-1:0] wb_adr;
  logic [31:0]           wb_mosi;
  logic [31:0]           wb_miso;
  logic                  wb_ack;
  logic                  wb_err;

  modport master (
    input  rx_data, rx_valid, tx_ready, wb_miso, wb_ack, wb_err,
    output rx_ready, tx_data, tx_valid,
    output wb_cyc, wb_stb, wb_we, wb_tag, wb_sel, wb_adr, wb_mosi
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, wb_miso, wb_ack, wb_err,
    input  rx_ready, tx_data, tx_valid,
    input  wb_cyc, wb_stb, wb_we, wb_tag, wb_sel, wb_adr, wb_mosi
  );
endinterface

// File: rtl/wb_stream_master.sv
// Byte-stream driven Wishbone master. Parses write (01 A0..A3 D0..D3) and
// read (02 A0..A3) commands, runs one classic bus cycle, and returns a status
// byte (plus four little-endian data bytes for reads).
module wb_stream_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input logic                sys_clk,
  input logic                sys_rst_n,
  wb_stream_master_if.master bus
);

  localparam logic [7:0] OP_WRITE   = 8'h01;
  localparam logic [7:0] OP_READ    = 8'h02;
  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_ERR     = 8'h01;
  localparam logic [7:0] ST_TIMEOUT = 8'h02;
  localparam logic [7:0] ST_BAD_OP  = 8'hFF;

  localparam int            TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;

  state_t        state;
  logic          is_write;
  logic [2:0]    cnt;        // byte index in ADDR/DATA/RESP
  logic [2:0]    resp_last;  // index of the final response byte
  logic [TW-1:0] tmo_cnt;
  logic [31:0]   adr_q;
  logic [31:0]   mosi_q;
  logic [31:0]   miso_q;
  logic [7:0]    status_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic          cyc_q;
  logic          we_q;

  // Response byte idx: status first, then read data least significant byte first.
  function automatic logic [7:0] resp_byte(input logic [2:0] idx,
                                           input logic [7:0] status,
                                           input logic [31:0] rdata);
    case (idx)
      3'd0:    return status;
      3'd1:    return rdata[7:0];
      3'd2:    return rdata[15:8];
      3'd3:    return rdata[23:16];
      default: return rdata[31:24];
    endcase
  endfunction

  // Command parser, bus sequencer and response serializer in one state machine.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      is_write   <= 1'b0;
      cnt        <= '0;
      resp_last  <= '0;
      tmo_cnt    <= '0;
      adr_q      <= '0;
      mosi_q     <= '0;
      miso_q     <= '0;
      status_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values of the others, regardless of statement order.
      case (state)
        S_IDLE: begin
          if (bus.rx_valid) begin
            cnt <= '0;
            if (bus.rx_data == OP_WRITE || bus.rx_data == OP_READ) begin
              is_write  <= (bus.rx_data == OP_WRITE);
              resp_last <= (bus.rx_data == OP_READ) ? 3'd4 : 3'd0;
              state     <= S_ADDR;
            end else begin
              status_q  <= ST_BAD_OP;
              resp_last <= 3'd0;
              state     <= S_RESP;
            end
          end
        end

        S_ADDR: begin
          if (bus.rx_valid) begin
            adr_q[8*cnt[1:0] +: 8] <= bus.rx_data;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd3) begin
              cnt <= '0;
              if (is_write) begin
                state <= S_DATA;
              end else begin
                state   <= S_BUS;
                cyc_q   <= 1'b1;
                we_q    <= 1'b0;
                tmo_cnt <= '0;
              end
            end
          end
        end

        S_DATA: begin
          if (bus.rx_valid) begin
            mosi_q[8*cnt[1:0] +: 8] <= bus.rx_data;
            cnt <= cnt + 3'd1;
            if (cnt == 3'd3) begin
              cnt     <= '0;
              state   <= S_BUS;
              cyc_q   <= 1'b1;
              we_q    <= 1'b1;
              tmo_cnt <= '0;
            end
          end
        end

        S_BUS: begin
          // Slave termination beats the timeout; err beats ack.
          if (bus.wb_err || bus.wb_ack || tmo_cnt == TMO_LAST) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            cnt   <= '0;
            state <= S_RESP;
            if (bus.wb_err) begin
              status_q <= ST_ERR;
              miso_q   <= '0;
            end else if (bus.wb_ack) begin
              status_q <= ST_OK;
              if (!is_write) miso_q <= bus.wb_miso;
            end else begin
              status_q <= ST_TIMEOUT;
              miso_q   <= '0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_RESP: begin
          // First RESP cycle only loads the byte; tx_valid rises the cycle after.
          if (!tx_valid_q) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= resp_byte(cnt, status_q, miso_q);
          end else if (bus.tx_ready) begin
            if (cnt == resp_last) begin
              tx_valid_q <= 1'b0;
              tx_data_q  <= '0;
              cnt        <= '0;
              state      <= S_IDLE;
            end else begin
              cnt       <= cnt + 3'd1;
              tx_data_q <= resp_byte(cnt + 3'd1, status_q, miso_q);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Only rx_ready and wb_sel are state decodes; everything else is a register.
  assign bus.rx_ready = (state == S_IDLE) || (state == S_ADDR) || (state == S_DATA);
  assign bus.wb_sel   = (state == S_BUS) ? 4'hF : 4'h0;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.wb_cyc   = cyc_q;
  assign bus.wb_stb   = cyc_q;
  assign bus.wb_we    = we_q;
  assign bus.wb_tag   = 1'b0;
  assign bus.wb_adr   = adr_q[ADDR_WIDTH-1:0];
  assign bus.wb_mosi  = mosi_q;

endmodule

// File: tb/tb_wb_stream_master.sv
// Randomized bench for wb_stream_master: commands are built from opcode,
// address, data and a chosen slave behaviour; the expected response bytes and
// bus-cycle length come from a small behavioural model of the command rules.
module tb_wb_stream_master;
  localparam int TMO = 16;

  logic sys_clk = 1'b0;
  logic sys_rst_n;

  wb_stream_master_if #(.ADDR_WIDTH(32)) bus ();

  wb_stream_master #(.ADDR_WIDTH(32), .TIMEOUT(TMO)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the last byte is taken.
  task automatic send_bytes(input logic [7:0] b[$]);
    foreach (b[i]) begin
      int w = 0;
      if (i > 0) repeat ($urandom_range(0, 2)) @(negedge sys_clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b[i];
      while (bus.rx_ready !== 1'b1 && w < 50) begin
        @(negedge sys_clk);
        w++;
      end
      if (w >= 50) check("rx_ready_wait", 64'(bus.rx_ready), 64'd1);
      @(negedge sys_clk);
      bus.rx_valid = 1'b0;
    end
  endtask

  // mode: 0 ack, 1 err, 2 err+ack, 3 no response. lat: cycles of cyc before the reply.
  task automatic run_cmd(input logic [7:0] op, input logic [31:0] adr, input logic [31:0] wd,
                         input logic [31:0] rd, input int mode, input int lat, input int stall);
    logic [7:0]  cmd[$];
    logic [7:0]  exp_rsp[$];
    logic [7:0]  got_rsp[$];
    logic [7:0]  st;
    logic [7:0]  prev_data;
    logic [31:0] cap_adr, cap_mosi;
    logic        cap_we, cap_stb;
    logic [3:0]  cap_sel;
    bit          is_bus, have_prev, hold_ok, quiet_ok, stable_ok;
    int          exp_cyc, n, cyc_cnt, cyc_first, tx_first, stall_left;

    // Reference model of the expected outcome.
    is_bus = (op == 8'h01) || (op == 8'h02);
    if (!is_bus) begin
      st = 8'hFF; exp_cyc = 0;
    end else if (mode == 3) begin
      st = 8'h02; exp_cyc = TMO;
    end else begin
      st = (mode == 0) ? 8'h00 : 8'h01; exp_cyc = lat + 1;
    end
    exp_rsp = {st};
    if (op == 8'h02)
      for (int i = 0; i < 4; i++) exp_rsp.push_back(st == 8'h00 ? rd[8*i +: 8] : 8'h00);
    cmd = {op};
    if (is_bus) for (int i = 0; i < 4; i++) cmd.push_back(adr[8*i +: 8]);
    if (op == 8'h01) for (int i = 0; i < 4; i++) cmd.push_back(wd[8*i +: 8]);

    bus.wb_miso = rd;
    send_bytes(cmd);

    n = 0; cyc_cnt = 0; cyc_first = -1; tx_first = -1; stall_left = stall;
    have_prev = 0; hold_ok = 1; quiet_ok = 1; stable_ok = 1; prev_data = 8'h00;
    cap_adr = '0; cap_mosi = '0; cap_we = 0; cap_stb = 0; cap_sel = '0;
    while (1) begin
      n++;
      if (bus.wb_cyc) begin
        if (cyc_first < 0) begin
          cyc_first = n; cap_adr = bus.wb_adr; cap_mosi = bus.wb_mosi;
          cap_we = bus.wb_we; cap_stb = bus.wb_stb; cap_sel = bus.wb_sel;
        end else if (bus.wb_adr !== cap_adr || bus.wb_mosi !== cap_mosi ||
                     bus.wb_we !== cap_we || bus.wb_stb !== cap_stb) begin
          stable_ok = 0;
        end
        if (bus.rx_ready !== 1'b0) quiet_ok = 0;
        bus.wb_ack = (cyc_cnt == lat) && (mode == 0 || mode == 2);
        bus.wb_err = (cyc_cnt == lat) && (mode == 1 || mode == 2);
        cyc_cnt++;
      end else begin
        bus.wb_ack = 1'b0;
        bus.wb_err = 1'b0;
        if (bus.wb_sel !== 4'h0) quiet_ok = 0;
      end
      if (bus.tx_valid) begin
        if (tx_first < 0) tx_first = n;
        if (bus.rx_ready !== 1'b0) quiet_ok = 0;
        if (have_prev && bus.tx_data !== prev_data) hold_ok = 0;
        if (stall_left > 0) begin
          bus.tx_ready = 1'b0; stall_left--;
        end else begin
          bus.tx_ready = ($urandom_range(0, 3) != 0);
        end
        if (bus.tx_ready) begin
          got_rsp.push_back(bus.tx_data); have_prev = 0;
        end else begin
          have_prev = 1; prev_data = bus.tx_data;
        end
      end else begin
        if (have_prev) hold_ok = 0;
        bus.tx_ready = 1'(($urandom_range(0, 1)));
      end
      // Stray bytes while busy must be ignored.
      bus.rx_valid = (bus.wb_cyc || bus.tx_valid) && ($urandom_range(0, 1) == 1);
      bus.rx_data  = 8'($urandom);
      if (got_rsp.size() >= exp_rsp.size() || n >= 200 + TMO) break;
      @(negedge sys_clk);
    end
    bus.rx_valid = 1'b0;
    @(negedge sys_clk);
    bus.tx_ready = 1'b0;

    check("rsp_len", 64'(got_rsp.size()), 64'(exp_rsp.size()));
    foreach (exp_rsp[i])
      check($sformatf("rsp_byte%0d op=%0h", i, op),
            (i < got_rsp.size()) ? 64'(got_rsp[i]) : 64'hx, 64'(exp_rsp[i]));
    check("cyc_cycles", 64'(cyc_cnt), 64'(exp_cyc));
    check("tx_first", 64'(tx_first), is_bus ? 64'(exp_cyc + 2) : 64'd2);
    if (is_bus) begin
      check("cyc_first", 64'(cyc_first), 64'd1);
      check("wb_adr", 64'(cap_adr), 64'(adr));
      check("wb_we_stb_sel", {cap_we, cap_stb, cap_sel}, {op == 8'h01, 1'b1, 4'hF});
      if (op == 8'h01) check("wb_mosi", 64'(cap_mosi), 64'(wd));
    end
    check("bus_stable", 64'(stable_ok), 64'd1);
    check("tx_hold", 64'(hold_ok), 64'd1);
    check("busy_quiet", 64'(quiet_ok), 64'd1);
    check("back_to_idle", {bus.tx_valid, bus.rx_ready, bus.wb_cyc}, 3'b010);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ctrl"}, {bus.rx_ready, bus.tx_valid, bus.wb_cyc, bus.wb_stb, bus.wb_we, bus.wb_tag},
          6'b100000);
    check({tag, "_sel"}, 64'(bus.wb_sel), 64'd0);
    check({tag, "_data"}, {bus.tx_data, bus.wb_adr, bus.wb_mosi}, 72'd0);
  endtask

  initial begin
    sys_rst_n    = 1'b0;
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    bus.wb_miso  = '0;
    bus.wb_ack   = 1'b0;
    bus.wb_err   = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_reset_values("in_reset");
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    check_reset_values("after_reset");

    // Directed cases.
    run_cmd(8'h01, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
    run_cmd(8'h02, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    run_cmd(8'h02, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 2, 0, 0);
    run_cmd(8'h02, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 3, 0, 0);
    run_cmd(8'h7A, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    run_cmd(8'h02, 32'h1234_5678, 32'h0, 32'hCAFE_F00D, 0, 2, 0);
    run_cmd(8'h02, 32'h0000_0010, 32'h0, 32'hA5A5_5A5A, 0, TMO - 1, 0);
    run_cmd(8'h01, 32'h0000_0020, 32'h0102_0304, 32'h0, 2, TMO - 1, 0);
    run_cmd(8'h02, 32'h0000_0040, 32'h0, 32'h1111_2222, 0, 1, 10);

    // Reset in the middle of a bus cycle.
    begin
      logic [7:0] rd_cmd[$];
      rd_cmd = {8'h02, 8'h10, 8'h00, 8'h00, 8'h00};
      send_bytes(rd_cmd);
      repeat (3) @(negedge sys_clk);
      check("cyc_before_rst", 64'(bus.wb_cyc), 64'd1);
      sys_rst_n = 1'b0;
      #1;
      check_reset_values("mid_bus_reset");
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      run_cmd(8'h02, 32'h0000_4000, 32'h0, 32'h7654_3210, 0, 0, 0);
    end

    // Random commands.
    for (int k = 0; k < 40; k++) begin
      logic [7:0] op;
      int mode, lat;
      case ($urandom_range(0, 9))
        0:       begin op = 8'($urandom); if (op == 8'h01 || op == 8'h02) op = 8'h00; end
        1, 2, 3, 4: op = 8'h01;
        default: op = 8'h02;
      endcase
      mode = int'($urandom_range(0, 3));
      lat  = ($urandom_range(0, 5) == 0) ? TMO - 1 : int'($urandom_range(0, 4));
      run_cmd(op, $urandom, $urandom, $urandom, mode, lat, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
